// File: rtl/cpu_fpu_div_arbiter_pkg.sv
// Shared types and constants for the CPU FPU divider arbiter.
// Holds the arbiter state encoding, float constants and the round-robin wrap helper.
package cpu_fpu_div_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_RESULT = 3'd2,
    ST_DRAIN       = 3'd3,
    ST_RESPOND     = 3'd4
  } arb_state_e;

  localparam logic [31:0] F_ONE     = 32'h3F80_0000;
  localparam logic [31:0] F_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] F_QNAN    = 32'hFFC0_0000;

  // Index following idx, wrapping back to port 0 after the last port.
  function automatic int rr_next(input int idx, input int num_ports);
    if (idx + 32'sd1 >= num_ports) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/cpu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_PORTS.
module cpu_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic                 valid,
  output logic [PORT_W-1:0]    idx
);

  int              cand_s;
  logic [PORT_W-1:0] cand_idx_s;

  // Scan ports starting at the pointer; the earliest hit wins.
  always_comb begin
    valid      = 1'b0;
    idx        = {PORT_W{1'b0}};
    cand_s     = 32'sd0;
    cand_idx_s = {PORT_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s = int'(ptr) + i;
      if (cand_s >= NUM_PORTS) begin
        cand_s = cand_s - NUM_PORTS;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = PORT_W'(cand_s);
      if (!valid && req[cand_idx_s]) begin
        valid = 1'b1;
        idx   = cand_idx_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/cpu_fpu_div_arbiter.sv
// Round-robin arbiter sharing one CPU_FPU_Div between NUM_PORTS requesters.
// Latches the winner's operands, runs the divider handshake, returns the result.
module cpu_fpu_div_arbiter
  import cpu_fpu_div_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_PORTS-1:0]    i_req,
  input  logic [NUM_PORTS*32-1:0] i_op1,
  input  logic [NUM_PORTS*32-1:0] i_op2,
  output logic [NUM_PORTS-1:0]    o_ready,
  output logic [31:0]             o_result,
  output logic                    o_busy,
  output logic [PORT_W-1:0]       o_grant,
  output logic                    o_div_request,
  output logic [31:0]             o_div_op1,
  output logic [31:0]             o_div_op2,
  input  logic                    i_div_ready,
  input  logic [31:0]             i_div_result
);

  arb_state_e           state_r, state_s;
  logic [NUM_PORTS-1:0] ready_r, ready_s;
  logic [31:0]          result_r, result_s;
  logic                 busy_r, busy_s;
  logic [PORT_W-1:0]    grant_r, grant_s;
  logic                 div_request_r, div_request_s;
  logic [31:0]          div_op1_r, div_op1_s;
  logic [31:0]          div_op2_r, div_op2_s;
  logic [31:0]          div_result_r, div_result_s;
  logic [PORT_W-1:0]    rr_ptr_r, rr_ptr_s;
  logic                 pick_valid_s;
  logic [PORT_W-1:0]    pick_idx_s;
  logic [PORT_W-1:0]    next_ptr_s;
  logic [31:0]          sel_op1_s, sel_op2_s;

  cpu_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign next_ptr_s = PORT_W'(rr_next(int'(grant_r), NUM_PORTS));

  // Operand mux for the picked port, using constant slice bounds per port.
  always_comb begin
    sel_op1_s = 32'h0000_0000;
    sel_op2_s = 32'h0000_0000;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_idx_s == PORT_W'(p)) begin
        sel_op1_s = i_op1[p*32 +: 32];
        sel_op2_s = i_op2[p*32 +: 32];
      end else begin
        sel_op1_s = sel_op1_s;
      end
    end
  end

  // Next-state and next-output logic; every output holds unless a state changes it.
  always_comb begin
    state_s       = state_r;
    ready_s       = ready_r;
    result_s      = result_r;
    busy_s        = busy_r;
    grant_s       = grant_r;
    div_request_s = div_request_r;
    div_op1_s     = div_op1_r;
    div_op2_s     = div_op2_r;
    div_result_s  = div_result_r;
    rr_ptr_s      = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        // A divider still showing ready (e.g. stuck after reset) blocks new grants.
        if (!i_div_ready && pick_valid_s) begin
          grant_s   = pick_idx_s;
          div_op1_s = sel_op1_s;
          div_op2_s = sel_op2_s;
          busy_s    = 1'b1;
          state_s   = ST_ISSUE;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        div_request_s = 1'b1;
        state_s       = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (i_div_ready) begin
          div_result_s  = i_div_result;
          div_request_s = 1'b0;
          state_s       = ST_DRAIN;
        end else begin
          div_request_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_div_ready) begin
          state_s = ST_DRAIN;
        end else if (i_req[grant_r]) begin
          result_s          = div_result_r;
          ready_s           = {NUM_PORTS{1'b0}};
          ready_s[grant_r]  = 1'b1;
          state_s           = ST_RESPOND;
        end else begin
          // Requester withdrew: drop the result and move on.
          rr_ptr_s = next_ptr_s;
          busy_s   = 1'b0;
          state_s  = ST_IDLE;
        end
      end
      ST_RESPOND: begin
        if (!i_req[grant_r]) begin
          ready_s  = {NUM_PORTS{1'b0}};
          rr_ptr_s = next_ptr_s;
          busy_s   = 1'b0;
          state_s  = ST_IDLE;
        end else begin
          ready_s = ready_r;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        ready_s       = {NUM_PORTS{1'b0}};
        busy_s        = 1'b0;
        div_request_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= ST_IDLE;
      ready_r       <= {NUM_PORTS{1'b0}};
      result_r      <= 32'h0000_0000;
      busy_r        <= 1'b0;
      grant_r       <= {PORT_W{1'b0}};
      div_request_r <= 1'b0;
      div_op1_r     <= 32'h0000_0000;
      div_op2_r     <= 32'h0000_0000;
      div_result_r  <= 32'h0000_0000;
      rr_ptr_r      <= {PORT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      ready_r       <= ready_s;
      result_r      <= result_s;
      busy_r        <= busy_s;
      grant_r       <= grant_s;
      div_request_r <= div_request_s;
      div_op1_r     <= div_op1_s;
      div_op2_r     <= div_op2_s;
      div_result_r  <= div_result_s;
      rr_ptr_r      <= rr_ptr_s;
    end
  end

  assign o_ready       = ready_r;
  assign o_result      = result_r;
  assign o_busy        = busy_r;
  assign o_grant       = grant_r;
  assign o_div_request = div_request_r;
  assign o_div_op1     = div_op1_r;
  assign o_div_op2     = div_op2_r;

endmodule

// File: tb/tb_cpu_fpu_div_arbiter.sv
// Self-checking bench for cpu_fpu_div_arbiter: directed scenarios plus randomized
// multi-port traffic against a round-robin reference model and a divider model.
module tb_cpu_fpu_div_arbiter;
  import cpu_fpu_div_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int PW = 2;

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic [N-1:0]      i_req;
  logic [N*32-1:0]   i_op1, i_op2;
  logic [N-1:0]      o_ready;
  logic [31:0]       o_result;
  logic              o_busy;
  logic [PW-1:0]     o_grant;
  logic              o_div_request;
  logic [31:0]       o_div_op1, o_div_op2;
  logic              i_div_ready;
  logic [31:0]       i_div_result;

  logic [31:0] op1_m [N];
  logic [31:0] op2_m [N];
  logic        dv_ready    = 1'b0;
  logic [31:0] dv_result   = 32'h0;
  logic        stuck_ready = 1'b0;
  int          n_chk = 0, n_err = 0, early_drop = 0, op_unstable = 0;

  assign i_op1        = {op1_m[2], op1_m[1], op1_m[0]};
  assign i_op2        = {op2_m[2], op2_m[1], op2_m[0]};
  assign i_div_ready  = dv_ready | stuck_ready;
  assign i_div_result = dv_result;

  cpu_fpu_div_arbiter #(.NUM_PORTS(N), .PORT_W(PW)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_op1         (i_op1),
    .i_op2         (i_op2),
    .o_ready       (o_ready),
    .o_result      (o_result),
    .o_busy        (o_busy),
    .o_grant       (o_grant),
    .o_div_request (o_div_request),
    .o_div_op1     (o_div_op1),
    .o_div_op2     (o_div_op2),
    .i_div_ready   (i_div_ready),
    .i_div_result  (i_div_result)
  );

  always #5 i_clock = ~i_clock;

  // Divider behaviour: known IEEE quotients for the directed cases, a scrambled tag otherwise.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == F_ONE && b == 32'h4040_0000) return 32'h3EAA_AAAB;
    if (a == F_ONE && b == 32'h0000_0000) return F_POS_INF;
    if (a == 32'h0000_0000 && b == 32'h0000_0000) return F_QNAN;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
  endfunction

  // Spec rule: first requesting port at or after the pointer, modulo N.
  function automatic logic [PW-1:0] model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return PW'((ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b);
    op1_m[p] = a;
    op2_m[p] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},   32'(o_ready), 32'h0);
    check_eq({tag, "_result"},  o_result, 32'h0);
    check_eq({tag, "_busy"},    32'(o_busy), 32'h0);
    check_eq({tag, "_grant"},   32'(o_grant), 32'h0);
    check_eq({tag, "_divreq"},  32'(o_div_request), 32'h0);
    check_eq({tag, "_divop1"},  o_div_op1, 32'h0);
    check_eq({tag, "_divop2"},  o_div_op2, 32'h0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_req = '0;
    stuck_ready = 1'b0;
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
  endtask

  // which: 0 = o_busy, 1 = o_div_request; bounded wait.
  task automatic wait_for(input int which, input string tag);
    logic c;
    for (int k = 0; k < 40; k++) begin
      c = (which == 0) ? o_busy : o_div_request;
      if (c) break;
      tick();
    end
    c = (which == 0) ? o_busy : o_div_request;
    check_eq(tag, 32'(c), 32'h1);
  endtask

  task automatic wait_ready(input int p, input string tag);
    for (int k = 0; k < 60; k++) begin
      if (o_ready[p]) break;
      check_eq({tag, "_onehot0"}, 32'($onehot0(o_ready)), 32'h1);
      tick();
    end
    check_eq({tag, "_ready"}, 32'(o_ready), 32'(1) << p);
  endtask

  task automatic run_traffic(input int n_txn, input int raise_pct, input int wd_pct,
                             input bit check_seq);
    int ptr_m = 0, served = 0, wd_cnt = 0, granted = 0, cyc = 0;
    logic busy_q = 1'b0, ready_q = 1'b0, withdrawn = 1'b0;
    logic [PW-1:0] gm = '0;
    logic [31:0] exp_res = 32'h0;
    while (served + wd_cnt < n_txn && cyc < 4000) begin
      tick();
      cyc++;
      if (o_busy && !busy_q) begin
        gm = model_pick(i_req, ptr_m);
        check_eq("grant", 32'(o_grant), 32'(gm));
        if (check_seq) check_eq("rr_seq", 32'(o_grant), 32'(granted % N));
        exp_res = ref_div(op1_m[gm], op2_m[gm]);
        withdrawn = 1'b0;
        granted++;
      end
      if (!o_busy && busy_q) ptr_m = (int'(gm) + 1) % N;
      check_eq("onehot0", 32'($onehot0(o_ready)), 32'h1);
      if (withdrawn) check_eq("wd_no_ready", 32'(o_ready), 32'h0);
      if (o_ready != '0 && !ready_q) begin
        check_eq("ready_port", 32'(o_ready), 32'(1) << gm);
        check_eq("result", o_result, exp_res);
        i_req[gm] = 1'b0;
        served++;
      end
      if (o_busy && !withdrawn && o_ready == '0 && i_req[gm] &&
          $urandom_range(0, 99) < wd_pct) begin
        i_req[gm] = 1'b0;
        withdrawn = 1'b1;
        wd_cnt++;
      end
      for (int p = 0; p < N; p++) begin
        if (!i_req[p] && !(o_busy && int'(o_grant) == p) &&
            $urandom_range(0, 99) < raise_pct) begin
          if ($urandom_range(0, 3) == 0) set_op(p, F_ONE, 32'h4040_0000);
          else set_op(p, $urandom, $urandom);
          i_req[p] = 1'b1;
        end
      end
      busy_q  = o_busy;
      ready_q = |o_ready;
    end
    check_eq("traffic_done", 32'(served + wd_cnt >= n_txn), 32'h1);
    i_req = '0;
    for (int k = 0; k < 50; k++) begin
      if (!o_busy) break;
      tick();
    end
    check_eq("drain_idle", 32'(o_busy), 32'h0);
  endtask

  // Divider model: four-phase handshake, random 1..4 cycle latency, sampled on negedge.
  initial begin
    int dv_phase, dv_cnt;
    logic [31:0] dv_a, dv_b;
    dv_phase = 0; dv_cnt = 0; dv_a = '0; dv_b = '0;
    forever begin
      @(negedge i_clock);
      if (!i_reset) begin
        dv_phase = 0;
        dv_ready = 1'b0;
      end else begin
        case (dv_phase)
          0: if (o_div_request) begin
               dv_a = o_div_op1; dv_b = o_div_op2;
               dv_cnt = $urandom_range(1, 4);
               dv_phase = 1;
             end
          1: begin
               if (!o_div_request) begin
                 early_drop++;
                 dv_phase = 0;
               end else begin
                 if (o_div_op1 != dv_a || o_div_op2 != dv_b) op_unstable++;
                 dv_cnt--;
                 if (dv_cnt == 0) begin
                   dv_result = ref_div(dv_a, dv_b);
                   dv_ready = 1'b1;
                   dv_phase = 2;
                 end
               end
             end
          default: if (!o_div_request) begin
               dv_ready = 1'b0;
               dv_phase = 0;
             end
        endcase
      end
    end
  end

  initial begin
    bit seen;
    i_reset = 1'b0;
    i_req = '0;
    for (int p = 0; p < N; p++) set_op(p, 32'h0, 32'h0);
    repeat (2) tick();
    check_all_zero("rst");
    i_reset = 1'b1;
    tick();

    // Single request 6/2 on port 0.
    set_op(0, 32'h40C0_0000, 32'h4000_0000);
    i_req[0] = 1'b1;
    wait_ready(0, "t1");
    check_eq("t1_result", o_result, 32'h4040_0000);
    i_req[0] = 1'b0;
    tick();
    check_eq("t1_ready_clr", 32'(o_ready), 32'h0);
    check_eq("t1_busy_clr", 32'(o_busy), 32'h0);

    // Simultaneous requests from reset: port 0 first, then port 1.
    do_reset();
    set_op(0, F_ONE, 32'h4040_0000);
    set_op(1, F_ONE, 32'h0000_0000);
    i_req = 3'b011;
    wait_ready(0, "t2a");
    check_eq("t2a_result", o_result, 32'h3EAA_AAAB);
    i_req[0] = 1'b0;
    wait_ready(1, "t2b");
    check_eq("t2b_result", o_result, 32'h7F80_0000);
    i_req[1] = 1'b0;
    tick();

    // Port 1 withdraws during WAIT_RESULT while port 0 is pending.
    do_reset();
    set_op(1, $urandom, $urandom);
    i_req[1] = 1'b1;
    wait_for(0, "t3_busy");
    check_eq("t3_grant1", 32'(o_grant), 32'h1);
    set_op(0, 32'h0, 32'h0);
    i_req[0] = 1'b1;
    wait_for(1, "t3_divreq");
    i_req[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      check_eq("t3_no_ready1", 32'(o_ready[1]), 32'h0);
      if (!seen) begin
        if (i_div_ready) seen = 1'b1;
        else check_eq("t3_req_held", 32'(o_div_request), 32'h1);
      end
      if (!o_busy) break;
    end
    wait_ready(0, "t3");
    check_eq("t3_grant0", 32'(o_grant), 32'h0);
    check_eq("t3_result", o_result, 32'hFFC0_0000);
    i_req[0] = 1'b0;
    tick();

    // Reset during WAIT_RESULT, then a divider stuck at ready must block grants.
    set_op(0, 32'h40C0_0000, 32'h4000_0000);
    i_req[0] = 1'b1;
    wait_for(1, "t4_divreq");
    i_reset = 1'b0;
    #1;
    check_all_zero("t4_rst");
    stuck_ready = 1'b1;
    tick();
    i_reset = 1'b1;
    repeat (4) begin
      tick();
      check_eq("t4_guard", 32'(o_busy), 32'h0);
    end
    stuck_ready = 1'b0;
    wait_ready(0, "t4");
    check_eq("t4_result", o_result, 32'h4040_0000);
    i_req[0] = 1'b0;
    tick();

    // Operand changes after the grant are ignored.
    set_op(0, 32'h40C0_0000, 32'h4000_0000);
    i_req[0] = 1'b1;
    wait_for(0, "t5_busy");
    set_op(0, 32'h4120_0000, F_ONE);
    wait_ready(0, "t5");
    check_eq("t5_result", o_result, 32'h4040_0000);
    check_eq("t5_divop1", o_div_op1, 32'h40C0_0000);
    i_req[0] = 1'b0;
    tick();

    // Continuous requests on all ports, then random traffic with withdrawals.
    do_reset();
    run_traffic(3 * N, 100, 0, 1'b1);
    do_reset();
    run_traffic(40, 50, 10, 1'b0);

    check_eq("early_drop", 32'(early_drop), 32'h0);
    check_eq("op_unstable", 32'(op_unstable), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
